// File: rtl/instr_encoder_pkg.sv
// Shared opcode, function and mnemonic definitions for the instruction
// encoder and decoder. Optional macro BYTE_WR_EN switches the memory write
// port from one 32-bit beat to four big-endian byte beats.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        stIdle  = 2'd0,
        stWrite = 2'd1,
        stDone  = 2'd2
    } stateT;

    // Mnemonic codes on the request port; code 15 is illegal
    localparam logic [3:0] mnADD  = 4'd0;
    localparam logic [3:0] mnSUB  = 4'd1;
    localparam logic [3:0] mnAND  = 4'd2;
    localparam logic [3:0] mnOR   = 4'd3;
    localparam logic [3:0] mnSLL  = 4'd4;
    localparam logic [3:0] mnSLT  = 4'd5;
    localparam logic [3:0] mnADDI = 4'd6;
    localparam logic [3:0] mnORI  = 4'd7;
    localparam logic [3:0] mnSW   = 4'd8;
    localparam logic [3:0] mnLW   = 4'd9;
    localparam logic [3:0] mnBEQ  = 4'd10;
    localparam logic [3:0] mnBNE  = 4'd11;
    localparam logic [3:0] mnBGTZ = 4'd12;
    localparam logic [3:0] mnJ    = 4'd13;
    localparam logic [3:0] mnHALT = 4'd14;

    // Primary opcodes
    localparam logic [5:0] opRFormat = 6'd0;
    localparam logic [5:0] opADDI    = 6'd8;
    localparam logic [5:0] opORI     = 6'd13;
    localparam logic [5:0] opSW      = 6'd43;
    localparam logic [5:0] opLW      = 6'd35;
    localparam logic [5:0] opBEQ     = 6'd4;
    localparam logic [5:0] opBNE     = 6'd5;
    localparam logic [5:0] opBGTZ    = 6'd7;
    localparam logic [5:0] opJ       = 6'd2;
    localparam logic [5:0] opHALT    = 6'd63;

    // R-format function codes
    localparam logic [5:0] funcADD = 6'd32;
    localparam logic [5:0] funcSUB = 6'd34;
    localparam logic [5:0] funcAND = 6'd36;
    localparam logic [5:0] funcOR  = 6'd37;
    localparam logic [5:0] funcSLL = 6'd0;
    localparam logic [5:0] funcSLT = 6'd42;

`ifdef BYTE_WR_EN
    localparam int imDataW = 8;
`else
    localparam int imDataW = 32;
`endif

endpackage

// File: rtl/instr_pack.sv
// Combinational mnemonic-to-machine-word packer. Forces the unused register
// or shift field to zero per instruction format and flags illegal codes.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the instruction format and fill its fields
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (mnem)
            mnADD:   word = {opRFormat, rs, rt, rd, 5'd0, funcADD};
            mnSUB:   word = {opRFormat, rs, rt, rd, 5'd0, funcSUB};
            mnAND:   word = {opRFormat, rs, rt, rd, 5'd0, funcAND};
            mnOR:    word = {opRFormat, rs, rt, rd, 5'd0, funcOR};
            mnSLL:   word = {opRFormat, 5'd0, rt, rd, sa, funcSLL};
            mnSLT:   word = {opRFormat, rs, rt, rd, 5'd0, funcSLT};
            mnADDI:  word = {opADDI, rs, rt, imm};
            mnORI:   word = {opORI, rs, rt, imm};
            mnSW:    word = {opSW, rs, rt, imm};
            mnLW:    word = {opLW, rs, rt, imm};
            mnBEQ:   word = {opBEQ, rs, rt, imm};
            mnBNE:   word = {opBNE, rs, rt, imm};
            mnBGTZ:  word = {opBGTZ, rs, 5'd0, imm};
            mnJ:     word = {opJ, target};
            mnHALT:  word = {opHALT, 26'd0};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one mnemonic request per handshake, packs it
// into a machine word and writes it to instruction memory at consecutive
// word addresses from BASE_ADDR. Optional macro BYTE_WR_EN splits each
// write into four big-endian byte beats at consecutive byte addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               InValid,
    output logic               InReady,
    input  logic [3:0]         Mnem,
    input  logic [4:0]         Rs,
    input  logic [4:0]         Rt,
    input  logic [4:0]         Rd,
    input  logic [4:0]         Sa,
    input  logic [15:0]        Imm,
    input  logic [25:0]        Target,
    output logic [31:0]        IMAddr,
    output logic [imDataW-1:0] IMData,
    output logic               IMWr,
    output logic               Done,
    output logic               Err
);

    localparam int countW = $clog2(DEPTH_WORDS + 1);

    stateT             state;
    stateT             nextState;
    logic [countW-1:0] count;
    logic [31:0]       packedWord;
    logic              legal;
    logic [31:0]       word_p1;
    logic              halt_p1;
    logic              errPulse;
    logic              errSticky;
    logic              doneFlag;
    logic              handshake;
    logic              full;
    logic              accept;
    logic              lastBeat;
`ifdef BYTE_WR_EN
    logic [1:0]        byteIdx;
`endif

    instr_pack uPack (
        .mnem   (Mnem),
        .rs     (Rs),
        .rt     (Rt),
        .rd     (Rd),
        .sa     (Sa),
        .imm    (Imm),
        .target (Target),
        .word   (packedWord),
        .legal  (legal)
    );

    assign handshake = InValid && InReady;
    assign full      = (count == countW'(DEPTH_WORDS));
    // A request becomes a memory write only when legal and there is room
    assign accept    = handshake && !full && legal;
`ifdef BYTE_WR_EN
    assign lastBeat  = (byteIdx == 2'd3);
`else
    assign lastBeat  = 1'b1;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= stIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: full memory wins over illegal code; DONE is absorbing
    always_comb begin
        nextState = state;
        case (state)
            stIdle: begin
                if (handshake && full) begin
                    nextState = stDone;
                end else if (accept) begin
                    nextState = stWrite;
                end
            end
            stWrite: begin
                if (lastBeat) begin
                    nextState = halt_p1 ? stDone : stIdle;
                end
            end
            stDone:  nextState = stDone;
            default: nextState = stIdle;
        endcase
    end

    // Capture the packed word on an accepted handshake (stage 1 register)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            word_p1 <= 32'd0;
            halt_p1 <= 1'b0;
        end else if (accept) begin
            word_p1 <= packedWord;
            halt_p1 <= (Mnem == mnHALT);
        end
    end

    // Word counter and byte sequencer advance through the write beats
    always_ff @(posedge CLK) begin
        if (!RST) begin
            count <= '0;
`ifdef BYTE_WR_EN
            byteIdx <= 2'd0;
`endif
        end else if (state == stWrite) begin
`ifdef BYTE_WR_EN
            byteIdx <= byteIdx + 2'd1;
`endif
            if (lastBeat) begin
                count <= count + 1'b1;
            end
        end
    end

    // Status flags: illegal pulse, sticky overflow, sticky halt-written
    always_ff @(posedge CLK) begin
        if (!RST) begin
            errPulse  <= 1'b0;
            errSticky <= 1'b0;
            doneFlag  <= 1'b0;
        end else begin
            errPulse <= handshake && !full && !legal;
            if (handshake && full) begin
                errSticky <= 1'b1;
            end
            if ((state == stWrite) && lastBeat && halt_p1) begin
                doneFlag <= 1'b1;
            end
        end
    end

    // Outputs decoded from state, counter and captured word
    always_comb begin
        InReady = (state == stIdle);
        IMWr    = (state == stWrite);
        Done    = doneFlag;
        Err     = errPulse | errSticky;
`ifdef BYTE_WR_EN
        IMAddr  = BASE_ADDR + (32'(count) << 2) + 32'(byteIdx);
        case (byteIdx)
            2'd0:    IMData = word_p1[31:24];
            2'd1:    IMData = word_p1[23:16];
            2'd2:    IMData = word_p1[15:8];
            default: IMData = word_p1[7:0];
        endcase
`else
        IMAddr  = BASE_ADDR + (32'(count) << 2);
        IMData  = word_p1;
`endif
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// request streams checked against a field-arithmetic reference encoder.
module tb_instr_encoder;

`ifdef BYTE_WR_EN
    localparam int BEATS = 4;
    localparam int DW    = 8;
`else
    localparam int BEATS = 1;
    localparam int DW    = 32;
`endif
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    // Opcode and function values by mnemonic code
    localparam int unsigned OPTAB [16] = '{0, 0, 0, 0, 0, 0, 8, 13, 43, 35, 4, 5, 7, 2, 63, 0};
    localparam int unsigned FNTAB [6]  = '{32, 34, 36, 37, 0, 42};

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [3:0]    Mnem = 4'd0;
    logic [4:0]    Rs = 5'd0;
    logic [4:0]    Rt = 5'd0;
    logic [4:0]    Rd = 5'd0;
    logic [4:0]    Sa = 5'd0;
    logic [15:0]   Imm = 16'd0;
    logic [25:0]   Target = 26'd0;
    logic [31:0]   IMAddr;
    logic [DW-1:0] IMData;
    logic          IMWr;
    logic          Done;
    logic          Err;

    int vectors     = 0;
    int miscompares = 0;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .InValid (InValid),
        .InReady (InReady),
        .Mnem    (Mnem),
        .Rs      (Rs),
        .Rt      (Rt),
        .Rd      (Rd),
        .Sa      (Sa),
        .Imm     (Imm),
        .Target  (Target),
        .IMAddr  (IMAddr),
        .IMData  (IMData),
        .IMWr    (IMWr),
        .Done    (Done),
        .Err     (Err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder built from the field layout with plain arithmetic
    function automatic logic [31:0] refEncode(input int m, input int rs, input int rt,
                                              input int rd, input int sa, input int imm,
                                              input int tgt);
        int unsigned w;
        int unsigned rsE;
        int unsigned rtE;
        int unsigned saE;
        rsE = (m == 4) ? 0 : rs;
        saE = (m == 4) ? sa : 0;
        rtE = (m == 12) ? 0 : rt;
        if (m <= 5)
            w = rsE * 2097152 + int'(rt) * 65536 + rd * 2048 + saE * 64 + FNTAB[m];
        else if (m <= 12)
            w = OPTAB[m] * 67108864 + rs * 2097152 + rtE * 65536 + imm;
        else if (m == 13)
            w = OPTAB[m] * 67108864 + tgt;
        else if (m == 14)
            w = OPTAB[m] * 67108864;
        else
            w = 0;
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic doReset();
        RST = 1'b0;
        InValid = 1'b0;
        tick(2);
        RST = 1'b1;
    endtask

    // Present a request and wait (bounded) for the handshake edge
    task automatic request(input int m, input int rs, input int rt, input int rd,
                           input int sa, input int imm, input int tgt,
                           input bit keep, input int limit, output bit ok);
        Mnem = 4'(m);
        Rs = 5'(rs);
        Rt = 5'(rt);
        Rd = 5'(rd);
        Sa = 5'(sa);
        Imm = 16'(imm);
        Target = 26'(tgt);
        InValid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge CLK);
            if (InReady === 1'b1) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) tick(1);
        if (!keep) InValid = 1'b0;
    endtask

    // Observe the write window following a handshake, reassembling the word
    task automatic capture(output logic [31:0] word, output logic [31:0] addr,
                           output int nwr, output bit addrBad);
        word = 32'd0;
        addr = 32'd0;
        nwr = 0;
        addrBad = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            if (IMWr === 1'b1) begin
                if (nwr == 0) addr = IMAddr;
                else if (IMAddr !== addr + 32'(nwr)) addrBad = 1'b1;
                word = (BEATS == 1) ? 32'(IMData) : ((word << 8) | 32'(IMData));
                nwr++;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        InValid = 1'b1;
        Mnem = 4'd0;
        tick(2);
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL reset_inready: got %b want 1", InReady); end
        vectors++; if (IMWr !== 1'b0) begin miscompares++; $display("FAIL reset_imwr: got %b want 0", IMWr); end
        vectors++; if (IMAddr !== BASE) begin miscompares++; $display("FAIL reset_imaddr: got %h want %h", IMAddr, BASE); end
        vectors++; if (IMData !== '0) begin miscompares++; $display("FAIL reset_imdata: got %h want 0", IMData); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", Done); end
        vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", Err); end
        InValid = 1'b0;
        RST = 1'b1;
    endtask

    task automatic test_add();
        bit ok; bit bad; int nwr; logic [31:0] w; logic [31:0] a;
        doReset();
        request(0, 1, 2, 3, 7, 0, 0, 1'b0, 20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL add_handshake: got none want handshake"); end
        vectors++; if (IMWr !== 1'b1) begin miscompares++; $display("FAIL add_latency: IMWr got %b want 1", IMWr); end
        capture(w, a, nwr, bad);
        vectors++; if (nwr != BEATS) begin miscompares++; $display("FAIL add_beats: got %0d want %0d", nwr, BEATS); end
        vectors++; if (a !== BASE) begin miscompares++; $display("FAIL add_addr: got %h want %h", a, BASE); end
        vectors++; if (w !== 32'h00221820) begin miscompares++; $display("FAIL add_data: got %h want 00221820", w); end
        vectors++; if (bad) begin miscompares++; $display("FAIL add_byteaddr: got non-consecutive want consecutive"); end
        vectors++; if (IMWr !== 1'b0 || InReady !== 1'b1) begin miscompares++; $display("FAIL add_after: IMWr=%b InReady=%b want 0/1", IMWr, InReady); end
    endtask

    task automatic test_sll();
        bit ok; bit bad; int nwr; logic [31:0] w; logic [31:0] a;
        doReset();
        request(4, 9, 2, 4, 3, 0, 0, 1'b0, 20, ok);
        capture(w, a, nwr, bad);
        vectors++; if (w[25:21] !== 5'd0) begin miscompares++; $display("FAIL sll_rs: got %0d want 0", w[25:21]); end
        vectors++; if (w[10:6] !== 5'd3) begin miscompares++; $display("FAIL sll_sa: got %0d want 3", w[10:6]); end
        vectors++; if (w[5:0] !== 6'd0) begin miscompares++; $display("FAIL sll_func: got %0d want 0", w[5:0]); end
        vectors++; if (w !== refEncode(4, 9, 2, 4, 3, 0, 0)) begin miscompares++; $display("FAIL sll_word: got %h want %h", w, refEncode(4, 9, 2, 4, 3, 0, 0)); end
    endtask

    task automatic test_back_to_back();
        bit ok; bit bad; int nwr; logic [31:0] w; logic [31:0] a; logic [31:0] exp;
        int m; int rs; int rt; int rd; int sa; int imm; int tgt;
        doReset();
        for (int i = 0; i < 3; i++) begin
            m = $urandom_range(0, 13); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
            rd = $urandom_range(0, 31); sa = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
            tgt = $urandom_range(0, 67108863);
            exp = refEncode(m, rs, rt, rd, sa, imm, tgt);
            request(m, rs, rt, rd, sa, imm, tgt, 1'b1, 20, ok);
            vectors++; if (!ok || InReady !== 1'b0) begin miscompares++; $display("FAIL b2b_ready0[%0d]: ok=%b InReady=%b want 1/0", i, ok, InReady); end
            capture(w, a, nwr, bad);
            vectors++; if (a !== BASE + 32'(4 * i) || nwr != BEATS || bad) begin miscompares++; $display("FAIL b2b_addr[%0d]: got %h/%0d want %h/%0d", i, a, nwr, BASE + 32'(4 * i), BEATS); end
            vectors++; if (w !== exp) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, w, exp); end
            vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1[%0d]: got %b want 1", i, InReady); end
        end
        InValid = 1'b0;
    endtask

    task automatic test_illegal();
        bit ok; bit bad; int nwr; logic [31:0] w; logic [31:0] a;
        doReset();
        request(15, 1, 1, 1, 1, 1, 1, 1'b0, 20, ok);
        vectors++; if (Err !== 1'b1 || IMWr !== 1'b0) begin miscompares++; $display("FAIL ill_pulse: Err=%b IMWr=%b want 1/0", Err, IMWr); end
        tick(1);
        vectors++; if (Err !== 1'b0 || IMWr !== 1'b0 || InReady !== 1'b1) begin miscompares++; $display("FAIL ill_clear: Err=%b IMWr=%b InReady=%b want 0/0/1", Err, IMWr, InReady); end
        request(3, 5, 6, 7, 0, 0, 0, 1'b0, 20, ok);
        capture(w, a, nwr, bad);
        vectors++; if (a !== BASE || nwr != BEATS) begin miscompares++; $display("FAIL ill_next_addr: got %h/%0d want %h/%0d", a, nwr, BASE, BEATS); end
        vectors++; if (w !== refEncode(3, 5, 6, 7, 0, 0, 0)) begin miscompares++; $display("FAIL ill_next_data: got %h want %h", w, refEncode(3, 5, 6, 7, 0, 0, 0)); end
    endtask

    task automatic test_halt();
        bit ok; bit bad; int nwr; logic [31:0] w; logic [31:0] a;
        doReset();
        request(6, 1, 2, 0, 0, 100, 0, 1'b0, 20, ok);
        capture(w, a, nwr, bad);
        request(14, 31, 31, 31, 31, 65535, 67108863, 1'b0, 20, ok);
        capture(w, a, nwr, bad);
        vectors++; if (w !== 32'hFC000000 || a !== BASE + 32'd4) begin miscompares++; $display("FAIL halt_word: got %h@%h want fc000000@%h", w, a, BASE + 32'd4); end
        vectors++; if (Done !== 1'b1 || InReady !== 1'b0) begin miscompares++; $display("FAIL halt_done: Done=%b InReady=%b want 1/0", Done, InReady); end
        request(0, 1, 1, 1, 0, 0, 0, 1'b0, 6, ok);
        vectors++; if (ok || IMWr !== 1'b0) begin miscompares++; $display("FAIL halt_absorb: handshake=%b IMWr=%b want 0/0", ok, IMWr); end
        vectors++; if (Done !== 1'b1 || Err !== 1'b0) begin miscompares++; $display("FAIL halt_sticky: Done=%b Err=%b want 1/0", Done, Err); end
    endtask

    task automatic test_full();
        bit ok; bit bad; int nwr; int errs; logic [31:0] w; logic [31:0] a; logic [31:0] exp;
        int m; int rs; int rt; int rd; int sa; int imm; int tgt;
        doReset();
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m = $urandom_range(0, 13); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
            rd = $urandom_range(0, 31); sa = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
            tgt = $urandom_range(0, 67108863);
            exp = refEncode(m, rs, rt, rd, sa, imm, tgt);
            request(m, rs, rt, rd, sa, imm, tgt, 1'b0, 20, ok);
            capture(w, a, nwr, bad);
            if (!ok || w !== exp || a !== BASE + 32'(4 * i) || nwr != BEATS || bad) begin
                errs++;
                if (errs < 4) $display("FAIL fill_word[%0d]: got %h@%h want %h@%h", i, w, a, exp, BASE + 32'(4 * i));
            end
        end
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL fill_total: got %0d bad writes want 0", errs); end
        request(0, 1, 2, 3, 0, 0, 0, 1'b0, 20, ok);
        vectors++; if (!ok || IMWr !== 1'b0 || Err !== 1'b1) begin miscompares++; $display("FAIL full_req: hs=%b IMWr=%b Err=%b want 1/0/1", ok, IMWr, Err); end
        tick(3);
        vectors++; if (Err !== 1'b1 || Done !== 1'b0) begin miscompares++; $display("FAIL full_sticky: Err=%b Done=%b want 1/0", Err, Done); end
        vectors++; if (InReady !== 1'b0 || IMWr !== 1'b0) begin miscompares++; $display("FAIL full_stop: InReady=%b IMWr=%b want 0/0", InReady, IMWr); end
    endtask

    task automatic test_random();
        bit ok; bit bad; int nwr; logic [31:0] w; logic [31:0] a; logic [31:0] exp;
        int m; int rs; int rt; int rd; int sa; int imm; int tgt;
        int refCount; bit refDone;
        doReset();
        refCount = 0;
        refDone = 1'b0;
        for (int i = 0; i < 40 && !refDone; i++) begin
            tick($urandom_range(0, 2));
            m = $urandom_range(0, 15);
            if (m == 14 && $urandom_range(0, 5) != 0) m = 15;
            rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            sa = $urandom_range(0, 31); imm = $urandom_range(0, 65535); tgt = $urandom_range(0, 67108863);
            request(m, rs, rt, rd, sa, imm, tgt, 1'b0, 20, ok);
            vectors++; if (!ok || Err !== (m == 15)) begin miscompares++; $display("FAIL rnd_err[%0d]: hs=%b Err=%b want 1/%b", i, ok, Err, m == 15); end
            capture(w, a, nwr, bad);
            if (m == 15) begin
                vectors++; if (nwr != 0) begin miscompares++; $display("FAIL rnd_nowrite[%0d]: got %0d writes want 0", i, nwr); end
            end else begin
                exp = refEncode(m, rs, rt, rd, sa, imm, tgt);
                vectors++; if (w !== exp || a !== BASE + 32'(4 * refCount) || nwr != BEATS || bad) begin miscompares++; $display("FAIL rnd_write[%0d]: got %h@%h want %h@%h", i, w, a, exp, BASE + 32'(4 * refCount)); end
                refCount++;
                if (m == 14) refDone = 1'b1;
            end
            vectors++; if (Done !== refDone || InReady !== !refDone) begin miscompares++; $display("FAIL rnd_status[%0d]: Done=%b InReady=%b want %b/%b", i, Done, InReady, refDone, !refDone); end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok; bit seen;
        doReset();
        request(0, 1, 2, 3, 7, 0, 0, 1'b0, 20, ok);
        if (BEATS > 1) tick(1);
        vectors++; if (IMWr !== 1'b1) begin miscompares++; $display("FAIL rstw_pending: IMWr got %b want 1", IMWr); end
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
        vectors++; if (IMWr !== 1'b0 || InReady !== 1'b1 || IMAddr !== BASE) begin miscompares++; $display("FAIL rstw_abort: IMWr=%b InReady=%b IMAddr=%h want 0/1/%h", IMWr, InReady, IMAddr, BASE); end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (IMWr !== 1'b0) seen = 1'b1;
            tick(1);
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL rstw_quiet: got IMWr after reset want none"); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sll();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_full();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
